// File: rtl/pipe_skid.sv
// pipe_skid: ready-side register slice (skid buffer) for a valid/ready stream.
// pin_ready comes straight from a flop, so upstream never sees a combinational
// path from pout_ready or flush. Two entries (main, skid) keep full
// throughput at 1 beat/cycle with 1-cycle latency.
// Optional: define PIPE_SKID_STAT_EN to add the saturating stall_cnt output.
module pipe_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             pin_valid,
    output logic             pin_ready,
    input  logic [WIDTH-1:0] pin_data,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [WIDTH-1:0] pout_data
`ifdef PIPE_SKID_STAT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic             r_pin_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    assign pin_ready  = r_pin_ready;
    assign pout_valid = (r_state != S_EMPTY) & ~flush;
    assign pout_data  = r_main;
    assign w_in_fire  = pin_valid & r_pin_ready;
    assign w_out_fire = pout_valid & pout_ready;

    // Next-state and entry update selection; flush drops held beats but keeps a same-cycle input.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            if (w_in_fire) begin
                w_state_nxt = S_BUSY;
                w_main_nxt  = pin_data;
            end else begin
                w_state_nxt = S_EMPTY;
            end
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = S_BUSY;
                        w_main_nxt  = pin_data;
                    end
                end
                S_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = pin_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = pin_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = S_BUSY;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // State, entries and registered ready (ready is derived from the next state).
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_pin_ready <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pin_ready <= (w_state_nxt != S_FULL);
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
        end
    end

`ifdef PIPE_SKID_STAT_EN
    logic [31:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Saturating count of cycles where a beat is offered but not accepted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (pout_valid && !pout_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// tb_pipe_skid: scoreboard bench for pipe_skid. Accepted beats are queued,
// delivered beats are popped and compared; occupancy of the queue predicts
// pin_ready and pout_valid every cycle. Define PIPE_SKID_STAT_EN to also
// exercise stall_cnt.
module tb_pipe_skid;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        pin_valid;
    logic        pin_ready;
    logic [15:0] pin_data;
    logic        pout_valid;
    logic        pout_ready;
    logic [15:0] pout_data;
`ifdef PIPE_SKID_STAT_EN
    logic [31:0] stall_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [15:0] sb[$];

    pipe_skid #(.WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .pin_valid  (pin_valid),
        .pin_ready  (pin_ready),
        .pin_data   (pin_data),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .pout_data  (pout_data)
`ifdef PIPE_SKID_STAT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: sample mid-cycle, then apply what the coming edge will do.
    always @(negedge clock) begin
        logic [15:0] exp_d;
        if (!reset) begin
            sb.delete();
        end else begin
            chk("pin_ready", {31'b0, pin_ready}, {31'b0, (sb.size() < 2)});
            chk("pout_valid", {31'b0, pout_valid}, {31'b0, (sb.size() != 0) && !flush});
            if (flush) begin
                sb.delete();
            end else if (pout_valid && pout_ready) begin
                if (sb.size() == 0) begin
                    chk("out_fire_empty", {31'b0, pout_valid}, 32'd0);
                end else begin
                    exp_d = sb.pop_front();
                    chk("pout_data", {16'b0, pout_data}, {16'b0, exp_d});
                end
            end
            if (pin_valid && pin_ready) sb.push_back(pin_data);
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        flush      = 1'b0;
        pin_valid  = 1'b0;
        pin_data   = '0;
        pout_ready = 1'b0;

        // Reset then idle
        do_reset();
        @(negedge clock);
        chk("rst_pin_ready", {31'b0, pin_ready}, 32'd1);
        chk("rst_pout_valid", {31'b0, pout_valid}, 32'd0);
        chk("rst_pout_data", {16'b0, pout_data}, 32'd0);
        cyc();

        // Streaming at full rate
        pout_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            pin_valid = 1'b1;
            pin_data  = 16'(i);
            cyc();
        end
        pin_valid = 1'b0;
        cyc();
        cyc();

        // Backpressure fill and drain
        pout_ready = 1'b0;
        pin_valid  = 1'b1;
        pin_data   = 16'h00A1;
        cyc();
        pin_data   = 16'h00A2;
        cyc();
        pin_valid  = 1'b0;
        @(negedge clock);
        chk("bp_pin_ready_full", {31'b0, pin_ready}, 32'd0);
        chk("bp_hold_a1", {16'b0, pout_data}, 32'h00A1);
        cyc();
        cyc();
        pout_ready = 1'b1;
        @(negedge clock);
        chk("bp_drain_a1", {16'b0, pout_data}, 32'h00A1);
        cyc();
        @(negedge clock);
        chk("bp_ready_back", {31'b0, pin_ready}, 32'd1);
        chk("bp_drain_a2", {16'b0, pout_data}, 32'h00A2);
        cyc();
        cyc();

        // Flush while full
        pout_ready = 1'b0;
        pin_valid  = 1'b1;
        pin_data   = 16'h00B1;
        cyc();
        pin_data   = 16'h00B2;
        cyc();
        pin_valid  = 1'b0;
        cyc();
        flush = 1'b1;
        @(negedge clock);
        chk("fl_full_valid", {31'b0, pout_valid}, 32'd0);
        chk("fl_full_ready", {31'b0, pin_ready}, 32'd0);
        cyc();
        flush = 1'b0;
        @(negedge clock);
        chk("fl_after_valid", {31'b0, pout_valid}, 32'd0);
        chk("fl_after_ready", {31'b0, pin_ready}, 32'd1);
        pout_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // Flush with concurrent input
        pout_ready = 1'b0;
        pin_valid  = 1'b1;
        pin_data   = 16'h00C1;
        cyc();
        flush      = 1'b1;
        pin_data   = 16'h00C2;
        cyc();
        flush      = 1'b0;
        pin_valid  = 1'b0;
        @(negedge clock);
        chk("flc_valid", {31'b0, pout_valid}, 32'd1);
        chk("flc_data", {16'b0, pout_data}, 32'h00C2);
        pout_ready = 1'b1;
        cyc();
        cyc();

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            pin_valid  = 1'($urandom_range(0, 1));
            pin_data   = 16'($urandom);
            pout_ready = 1'($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            cyc();
        end
        pin_valid  = 1'b0;
        flush      = 1'b0;
        pout_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        @(negedge clock);
        chk("drain_empty", sb.size(), 32'd0);
        cyc();

`ifdef PIPE_SKID_STAT_EN
        // Stall counter: 5 stalled cycles, flush cycle not counted, not cleared
        do_reset();
        @(negedge clock);
        chk("stat_rst", stall_cnt, 32'd0);
        pout_ready = 1'b0;
        pin_valid  = 1'b1;
        pin_data   = 16'h00D1;
        cyc();
        pin_valid  = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        @(negedge clock);
        chk("stat_five", stall_cnt, 32'd5);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clock);
        chk("stat_after_flush", stall_cnt, 32'd5);
        cyc();
        @(negedge clock);
        chk("stat_idle", stall_cnt, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid.md
Name: pipe_skid

Overview:
- Ready-side register slice (skid buffer) for the valid/ready pipeline handshake; the backward-direction counterpart to the forward valid/data pipe stage.
- Registers the ready path so that `pin_ready` never depends combinationally on `pout_ready`. This breaks long backpressure timing paths between pipeline stages of the cache datapath.
- Two storage entries, main and skid. Full throughput of 1 beat/cycle, 1-cycle latency. Same flush semantics as the forward pipe stage.

Parameters:
- WIDTH, 16, payload width in bits

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- flush  in  1  discard all held beats; masks pout_valid in the same cycle
- pin_valid  in  1  upstream beat valid
- pin_ready  out  1  upstream may transfer; driven directly from a flop
- pin_data  in  WIDTH  upstream payload
- pout_valid  out  1  downstream beat valid
- pout_ready  in  1  downstream accepts
- pout_data  out  WIDTH  downstream payload; always equals the main entry

Behaviour:
- Handshakes:
  - in_fire = pin_valid & pin_ready.
  - out_fire = pout_valid & pout_ready.
  - Data moves only on fire.
  - pin_valid and pin_data are sampled only when pin_ready=1.
- States:
  - EMPTY: 0 entries.
  - BUSY: main entry holds a beat.
  - FULL: main and skid entries both hold beats.
- Combinational outputs:
  - pout_valid = (state != EMPTY) & ~flush.
  - pout_data = main_q.
- Registered ready: pin_ready_q = (next_state != FULL). It is 1 in EMPTY/BUSY and 0 in FULL. It has no combinational path from pout_ready or flush.
- Transitions when flush=0:
  - EMPTY: in_fire -> BUSY, main<=pin_data; otherwise stay.
  - BUSY: in_fire & out_fire -> BUSY, main<=pin_data.
  - BUSY: in_fire & ~out_fire -> FULL, skid<=pin_data.
  - BUSY: ~in_fire & out_fire -> EMPTY.
  - BUSY: neither -> stay.
  - FULL: out_fire -> BUSY, main<=skid. Otherwise stay. No in_fire is possible because pin_ready=0.
- Transitions when flush=1:
  - All held beats are dropped. out_fire is impossible because pout_valid is masked.
  - An in_fire in the same cycle is retained: main<=pin_data, next state BUSY.
  - Otherwise the next state is EMPTY.
  - Flush in FULL: pin_ready=0 that cycle, next state EMPTY, pin_ready=1 the following cycle.
- Ordering: beats leave in acceptance order. The skid beat is never overtaken.
- Latency and throughput: a beat accepted in cycle N is visible on pout in cycle N+1. Sustains 1 beat/cycle while pout_ready=1.
- Reset (reset=0 at an edge):
  - state=EMPTY, pin_ready=1, main_q=0, skid_q=0, pout_valid=0.
  - Reset overrides flush and any handshake in the same cycle.
  - Reset asserted mid-stream drops all held beats.
- pout_valid must not drop without out_fire or flush. pout_data must be stable while pout_valid=1 and pout_ready=0.

Optional Feature:
- Macro: PIPE_SKID_STAT_EN.
- Defined:
  - Adds output stall_cnt [31:0].
  - Increments on every cycle with pout_valid=1 and pout_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: the port and counter are absent. Functional behaviour is otherwise identical.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> pin_ready=1, pout_valid=0, pout_data=0.
- Streaming: pout_ready=1, beats 0x0001..0x0010 on consecutive cycles -> each appears 1 cycle later, in order, pin_ready stays 1, no bubbles.
- Backpressure fill: send 0xA1, 0xA2 with pout_ready=0 -> state FULL, pin_ready=0 from the cycle after 0xA2. pout_data holds 0xA1. Raise pout_ready -> 0xA1 then 0xA2 delivered, pin_ready returns to 1 after the first drain.
- Flush while FULL: hold 0xB1/0xB2, assert flush 1 cycle -> pout_valid=0 that cycle and the next, neither beat is ever delivered, pin_ready=1 the next cycle.
- Flush with concurrent input: state BUSY holding 0xC1, flush=1 with pin_valid=1, pin_data=0xC2 -> next cycle pout_valid=1, pout_data=0xC2, 0xC1 is lost.
- Stat counter (PIPE_SKID_STAT_EN defined): 1 beat held with pout_ready=0 for 5 cycles, then 1 flush cycle -> stall_cnt=5; the flush cycle is not counted and stall_cnt is not cleared by flush.
